regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Arbitrates the single register-file write port (WE3/Addr3/WD3) between two requesters:
  - in-order execute/writeback results;
  - late load data returned by the data cache after a miss.
- Holds a per-register busy scoreboard for outstanding loads and produces the decode-stage hazard stall.
- Sits between the pipeline writeback stage, the cache return path and the register file.

Parameters:
- XLEN, 32, data width of register writes.
- LD_DEPTH, 2, load-return buffer depth in entries (power of two, ≥2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_we  in  1  execute/writeback result valid.
- ex_rd  in  5  execute destination register.
- ex_wd  in  XLEN  execute result.
- ld_issue  in  1  load accepted by the cache this cycle (marks rd busy).
- ld_issue_rd  in  5  destination of the issued load.
- ld_valid  in  1  cache load-return data valid.
- ld_rd  in  5  load-return destination.
- ld_wd  in  XLEN  load-return data.
- ld_ready  out  1  load return accepted (buffer not full).
- id_rs1  in  5  decode-stage source 1.
- id_rs2  in  5  decode-stage source 2.
- id_rd  in  5  decode-stage destination.
- id_we  in  1  decode instruction writes id_rd.
- hazard_stall  out  1  stall decode.
- rf_we  out  1  to register file WE3.
- rf_addr  out  5  to register file Addr3.
- rf_wd  out  XLEN  to register file WD3.
- busy  out  32  scoreboard vector; bit 0 is always 0.

Behaviour:
- Reset (async assert, sync-release sampling):
  - buffer emptied, busy=0;
  - ld_ready=1, rf_we=0, rf_addr=0, rf_wd=0, hazard_stall=0 while rst_n=0.
- Write-port grant, combinational each cycle, fixed priority:
  1. ex_we && ex_rd!=0 → rf_* driven from ex_*.
  2. Else buffer non-empty → head entry written and popped at the posedge.
  3. Else ld_valid && ld_ready → ld_* written directly (bypass, zero latency, nothing enqueued).
  4. Else rf_we=0.
- Register file commits on negedge. rf_* are stable from posedge to negedge, so they are a pure function of registered state plus current inputs.
- ex_we with ex_rd=0: treated as no request, so the load path may use the port.
- Load return handshake:
  - A transfer occurs when ld_valid && ld_ready. Data is either bypassed (case 3) or enqueued.
  - ld_ready = buffer not full. When full, the cache holds ld_* stable until accepted.
  - Simultaneous pop and push when full: ld_ready stays 0 that cycle (no same-cycle slot reuse).
  - Load returns complete in FIFO order.
  - ld_rd=0 is accepted and discarded (never written, never enqueued).
- Scoreboard:
  - busy[r] is set at the posedge when ld_issue && ld_issue_rd==r && r!=0.
  - busy[r] is cleared at the posedge when a load-path write to r is granted (case 2 or 3).
  - Set and clear of the same r in one cycle: set wins.
- hazard_stall =
  - (busy[id_rs1] && id_rs1!=0), or
  - (busy[id_rs2] && id_rs2!=0), or
  - (id_we && busy[id_rd] && id_rd!=0), which covers WAW.
  - Because WAW stalls, at most one outstanding load targets any register and no duplicate rd exists in the buffer.
- Combinational paths: hazard_stall reads current busy only; there is no bypass of a same-cycle clear. Stall releases the cycle after the write.
- Reset mid-operation: buffered load data is dropped and busy cleared. The cache and pipeline are reset in the same domain.

Decomposition:
- Shared package rv_pkg:
  - XLEN;
  - REG_ADDR_W=5;
  - REG_COUNT=32;
  - X0 constant (5'd0);
  - wb_entry struct {rd[4:0], wd[XLEN-1:0]}.
- One sub-module: wb_fifo
  - synchronous FIFO, depth LD_DEPTH, async active-low reset;
  - push/pop/full/empty/head;
  - pointer wrap with an extra MSB for full/empty discrimination.

Test Plan:
1. Reset: rst_n=0 mid-traffic with 2 buffered loads → busy=0, ld_ready=1, rf_we=0; after release, no stale writes.
2. Bypass: idle port, ld_valid, ld_rd=5, ld_wd=0xDEAD_BEEF → same cycle rf_we=1, rf_addr=5, rf_wd=0xDEADBEEF; busy[5] 1→0.
3. Conflict: ex_we (rd=3, wd=0x11) and ld_valid (rd=7, wd=0x22) together → ex written first; x7 written next cycle from the buffer.
4. Backpressure: ex_we held 1 (rd≠0) for 4 cycles, 3 load returns offered → ld_ready drops after 2 accepts. Once ex idles, writes drain in order, then the third load is accepted.
5. Scoreboard:
   - ld_issue rd=9, then decode id_rs2=9 → hazard_stall=1 until the cycle after x9 is written;
   - id_rs1=0 → never stalls;
   - id_we rd=9 while busy → stall (WAW).
6. Same-cycle set/clear: load return writes x4 while ld_issue_rd=4 → busy[4]=1 after the posedge.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared register-file writeback types: widths, the x0 constant and the
// buffered load-return entry.
package rv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wd;
  } wb_entry;

  localparam int ENTRY_W = $bits(wb_entry);
endpackage

// File: rtl/wb_fifo.sv
// Load-return buffer: synchronous FIFO of writeback entries. Pointers carry an
// extra wrap bit so full and empty are told apart without a counter.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [ENTRY_W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [ENTRY_W-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only visible once the write pointer passes it.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Shares the register-file write port between in-order execute results and
// late load returns, and tracks registers still waiting on a load.
module regfile_wb_scheduler #(
  parameter int XLEN     = rv_pkg::XLEN,
  parameter int LD_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_we,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_wd,
  input  logic            ld_issue,
  input  logic [4:0]      ld_issue_rd,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_wd,
  output logic            ld_ready,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_we,
  output logic            hazard_stall,
  output logic            rf_we,
  output logic [4:0]      rf_addr,
  output logic [XLEN-1:0] rf_wd,
  output logic [31:0]     busy
);
  import rv_pkg::*;

  // Load return handshake: a beat transfers when ld_valid && ld_ready. ld_ready
  // is simply "buffer not full", so a pop in a full cycle does not free a slot
  // for the same cycle; the cache holds ld_* stable until the transfer.

  logic                 ex_req;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 bypass;
  logic [ENTRY_W-1:0]   head_bits;
  wb_entry              head;
  wb_entry              push_entry;
  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] set_mask;
  logic [REG_COUNT-1:0] clr_mask;

  assign ex_req        = ex_we && (ex_rd != X0);
  assign ld_ready      = !fifo_full;
  assign head          = wb_entry'(head_bits);
  assign push_entry.rd = ld_rd;
  assign push_entry.wd = ld_wd;

  // Fixed priority: execute, then buffered loads, then a zero-latency bypass.
  always_comb begin
    rf_we    = 1'b0;
    rf_addr  = X0;
    rf_wd    = '0;
    fifo_pop = 1'b0;
    bypass   = 1'b0;
    clr_mask = '0;
    if (rst_n) begin
      if (ex_req) begin
        rf_we   = 1'b1;
        rf_addr = ex_rd;
        rf_wd   = ex_wd;
      end else if (!fifo_empty) begin
        rf_we            = 1'b1;
        rf_addr          = head.rd;
        rf_wd            = head.wd;
        fifo_pop         = 1'b1;
        clr_mask[head.rd] = 1'b1;
      end else if (ld_valid && ld_ready && (ld_rd != X0)) begin
        rf_we           = 1'b1;
        rf_addr         = ld_rd;
        rf_wd           = ld_wd;
        bypass          = 1'b1;
        clr_mask[ld_rd] = 1'b1;
      end
    end
  end

  // Loads to x0 are accepted but dropped here.
  assign fifo_push = ld_valid && ld_ready && (ld_rd != X0) && !bypass;

  always_comb begin
    set_mask = '0;
    if (ld_issue && (ld_issue_rd != X0)) set_mask[ld_issue_rd] = 1'b1;
  end

  // Set is applied after clear so a same-cycle reissue keeps the register busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= ((busy_q & ~clr_mask) | set_mask) & {{(REG_COUNT-1){1'b1}}, 1'b0};
    end
  end

  assign busy = busy_q;

  assign hazard_stall = ((id_rs1 != X0) && busy_q[id_rs1])
                     || ((id_rs2 != X0) && busy_q[id_rs2])
                     || (id_we && (id_rd != X0) && busy_q[id_rd]);

  wb_fifo #(
    .DEPTH(LD_DEPTH)
  ) u_ld_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (head_bits)
  );
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios plus random traffic, all
// checked every cycle against a queue-based model of the write-port rules.
module tb_regfile_wb_scheduler;
  localparam int LD_DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        ex_we;
  logic [4:0]  ex_rd;
  logic [31:0] ex_wd;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_wd;
  logic        ld_ready;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_we;
  logic        hazard_stall;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd;
  logic [31:0] busy;

  regfile_wb_scheduler #(
    .XLEN(32),
    .LD_DEPTH(LD_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ex_we       (ex_we),
    .ex_rd       (ex_rd),
    .ex_wd       (ex_wd),
    .ld_issue    (ld_issue),
    .ld_issue_rd (ld_issue_rd),
    .ld_valid    (ld_valid),
    .ld_rd       (ld_rd),
    .ld_wd       (ld_wd),
    .ld_ready    (ld_ready),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_we       (id_we),
    .hazard_stall(hazard_stall),
    .rf_we       (rf_we),
    .rf_addr     (rf_addr),
    .rf_wd       (rf_wd),
    .busy        (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  logic [31:0] busy_m;
  logic [36:0] exp_q[$];
  logic [4:0]  out_q[$];
  logic        acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp_v, $time);
    end
  endtask

  task automatic idle();
    ex_we = 1'b0; ex_rd = '0; ex_wd = '0;
    ld_issue = 1'b0; ld_issue_rd = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_wd = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_we = 1'b0;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard step: predict this cycle's port use from the model, compare,
  // then apply what the coming posedge commits.
  task automatic step();
    logic        exp_ready;
    logic        e_we;
    logic        byp;
    logic        pop;
    logic        e_stall;
    logic [4:0]  e_addr;
    logic [31:0] e_wd;
    logic [31:0] clr;
    logic [36:0] hd;
    @(negedge clk);
    if (!rst_n) begin
      busy_m = '0;
      exp_q.delete();
    end
    exp_ready = (exp_q.size() < LD_DEPTH);
    e_we = 1'b0; e_addr = '0; e_wd = '0; byp = 1'b0; pop = 1'b0; clr = '0;
    if (rst_n) begin
      if (ex_we && ex_rd != 0) begin
        e_we = 1'b1; e_addr = ex_rd; e_wd = ex_wd;
      end else if (exp_q.size() > 0) begin
        hd = exp_q[0];
        e_we = 1'b1; e_addr = hd[36:32]; e_wd = hd[31:0]; pop = 1'b1;
        clr[e_addr] = 1'b1;
      end else if (ld_valid && exp_ready && ld_rd != 0) begin
        e_we = 1'b1; e_addr = ld_rd; e_wd = ld_wd; byp = 1'b1;
        clr[ld_rd] = 1'b1;
      end
    end
    acc = rst_n && ld_valid && exp_ready;
    e_stall = (id_rs1 != 0 && busy_m[id_rs1]) || (id_rs2 != 0 && busy_m[id_rs2])
           || (id_we && id_rd != 0 && busy_m[id_rd]);
    check("rf_we", {31'd0, rf_we}, {31'd0, e_we});
    if (e_we || !rst_n) begin
      check("rf_addr", {27'd0, rf_addr}, {27'd0, e_addr});
      check("rf_wd", rf_wd, e_wd);
    end
    check("ld_ready", {31'd0, ld_ready}, {31'd0, exp_ready});
    check("hazard_stall", {31'd0, hazard_stall}, {31'd0, e_stall});
    check("busy", busy, busy_m);
    if (rst_n) begin
      if (pop) void'(exp_q.pop_front());
      if (acc && ld_rd != 0 && !byp) exp_q.push_back({ld_rd, ld_wd});
      busy_m = busy_m & ~clr;
      if (ld_issue && ld_issue_rd != 0) busy_m[ld_issue_rd] = 1'b1;
    end
  endtask

  initial begin
    logic [4:0] r;
    n_checks = 0; n_fail = 0; acc = 1'b0; busy_m = '0;
    rst_n = 1'b0;
    idle();
    step(); adv();
    step(); adv();
    rst_n = 1'b1;

    // bypass on an idle port
    idle(); ld_issue = 1'b1; ld_issue_rd = 5'd5; step(); adv();
    idle(); ld_valid = 1'b1; ld_rd = 5'd5; ld_wd = 32'hDEAD_BEEF; step();
    check("byp_we", {31'd0, rf_we}, 32'd1);
    check("byp_addr", {27'd0, rf_addr}, 32'd5);
    check("byp_wd", rf_wd, 32'hDEAD_BEEF);
    check("byp_busy_before", {31'd0, busy[5]}, 32'd1);
    adv();
    idle(); step();
    check("byp_busy_after", {31'd0, busy[5]}, 32'd0);
    adv();

    // execute and load return in the same cycle
    idle(); ld_issue = 1'b1; ld_issue_rd = 5'd7; step(); adv();
    idle(); ex_we = 1'b1; ex_rd = 5'd3; ex_wd = 32'h11;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_wd = 32'h22; step();
    check("conf_ex_addr", {27'd0, rf_addr}, 32'd3);
    check("conf_ex_wd", rf_wd, 32'h11);
    adv();
    idle(); step();
    check("conf_ld_addr", {27'd0, rf_addr}, 32'd7);
    check("conf_ld_wd", rf_wd, 32'h22);
    adv();

    // backpressure: execute holds the port while three loads return
    for (int i = 0; i < 3; i++) begin
      idle(); ld_issue = 1'b1; ld_issue_rd = 5'(10 + i); step(); adv();
    end
    idle(); ld_valid = 1'b1; ld_rd = 5'd10; ld_wd = 32'hA0;
    for (int c = 0; c < 7; c++) begin
      ex_we = (c < 4); ex_rd = 5'd1; ex_wd = 32'(c);
      step();
      if (c == 2) check("bp_ready_low", {31'd0, ld_ready}, 32'd0);
      if (c >= 4) check("bp_drain_addr", {27'd0, rf_addr}, 32'(10 + c - 4));
      adv();
      if (acc) begin
        if (ld_rd == 5'd12) ld_valid = 1'b0;
        else begin ld_rd = ld_rd + 5'd1; ld_wd = ld_wd + 32'd1; end
      end
    end

    // scoreboard stalls
    idle(); ld_issue = 1'b1; ld_issue_rd = 5'd9; step(); adv();
    idle(); id_rs2 = 5'd9; step();
    check("stall_rs2", {31'd0, hazard_stall}, 32'd1); adv();
    idle(); id_rs1 = 5'd0; id_rs2 = 5'd1; step();
    check("no_stall_x0", {31'd0, hazard_stall}, 32'd0); adv();
    idle(); id_we = 1'b1; id_rd = 5'd9; step();
    check("stall_waw", {31'd0, hazard_stall}, 32'd1); adv();
    idle(); id_rs2 = 5'd9; ld_valid = 1'b1; ld_rd = 5'd9; ld_wd = 32'h99; step();
    check("stall_during_wr", {31'd0, hazard_stall}, 32'd1);
    check("stall_wr_addr", {27'd0, rf_addr}, 32'd9); adv();
    idle(); id_rs2 = 5'd9; step();
    check("stall_released", {31'd0, hazard_stall}, 32'd0); adv();

    // same-cycle set and clear of x4
    idle(); ld_issue = 1'b1; ld_issue_rd = 5'd4; step(); adv();
    idle(); ld_valid = 1'b1; ld_rd = 5'd4; ld_wd = 32'h44;
    ld_issue = 1'b1; ld_issue_rd = 5'd4; step(); adv();
    idle(); step();
    check("setclr_busy4", {31'd0, busy[4]}, 32'd1); adv();

    // reset with two buffered loads
    idle(); ld_issue = 1'b1; ld_issue_rd = 5'd20; step(); adv();
    idle(); ld_issue = 1'b1; ld_issue_rd = 5'd21; step(); adv();
    idle(); ex_we = 1'b1; ex_rd = 5'd2; ex_wd = 32'h5;
    ld_valid = 1'b1; ld_rd = 5'd20; ld_wd = 32'h2020; step(); adv();
    ld_rd = 5'd21; ld_wd = 32'h2121; step(); adv();
    rst_n = 1'b0; step();
    check("rst_we", {31'd0, rf_we}, 32'd0);
    check("rst_ready", {31'd0, ld_ready}, 32'd1);
    check("rst_busy", busy, 32'd0);
    adv();
    rst_n = 1'b1; idle();
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_no_write", {31'd0, rf_we}, 32'd0);
      adv();
    end

    // random traffic
    out_q.delete();
    idle();
    for (int n = 0; n < 600; n++) begin
      if (acc || !ld_valid) begin
        ld_valid = 1'b0;
        if (out_q.size() > 0 && $urandom_range(0, 2) != 0) begin
          ld_valid = 1'b1; ld_rd = out_q.pop_front(); ld_wd = $urandom;
        end else if ($urandom_range(0, 19) == 0) begin
          ld_valid = 1'b1; ld_rd = 5'd0; ld_wd = $urandom;
        end
      end
      r = 5'($urandom_range(1, 7));
      ld_issue = 1'b0; ld_issue_rd = r;
      if ($urandom_range(0, 2) == 0 && !busy_m[r] && !(ld_valid && ld_rd == r)) begin
        ld_issue = 1'b1;
        out_q.push_back(r);
      end
      ex_we = 1'($urandom_range(0, 1));
      ex_rd = 5'($urandom_range(0, 31));
      ex_wd = $urandom;
      id_rs1 = 5'($urandom_range(0, 7));
      id_rs2 = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_we = 1'($urandom_range(0, 1));
      step();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
